// File: rtl/hid_pkg.sv
// Shared command codes, packet lengths and state encodings for the HID host initiator.
package hid_pkg;
  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_KBD    = 8'h01;
  localparam logic [7:0] CMD_MOUSE  = 8'h02;
  localparam logic [7:0] CMD_JOY    = 8'h03;
  localparam logic [7:0] CMD_DB9    = 8'h04;
  localparam int MAX_BYTES = 6;

  typedef logic [MAX_BYTES-1:0][7:0] pkt_t;  // byte 0 is the command byte

  typedef enum logic [1:0] {H_INIT_STAT, H_INIT_ARM, H_IDLE} host_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP, TX_SAMPLE} tx_state_t;

  function automatic logic [2:0] pkt_len(input logic [7:0] cmd);
    case (cmd)
      CMD_STATUS: pkt_len = 3'd3;
      CMD_KBD:    pkt_len = 3'd2;
      CMD_MOUSE:  pkt_len = 3'd4;
      CMD_JOY:    pkt_len = 3'd6;
      CMD_DB9:    pkt_len = 3'd2;
      default:    pkt_len = 3'd1;
    endcase
  endfunction
endpackage

// File: rtl/hid_pkt_tx.sv
// Packet serializer: strobes up to six bytes STROBE_GAP cycles apart, then optionally
// flags the reply sample cycle STROBE_GAP cycles after the last strobe.
module hid_pkt_tx import hid_pkg::*; #(
  parameter int STROBE_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  pkt_t       pkt,
  input  logic [2:0] len,
  input  logic       rd,
  output logic       strobe,
  output logic       start,
  output logic [7:0] dout,
  output logic       last,
  output logic       sample,
  output logic       idle,
  output logic [7:0] cmd
);
  localparam logic [7:0] GAP_LOAD = 8'(STROBE_GAP - 1);

  tx_state_t  state, state_nx;
  pkt_t       pkt_q;
  logic [2:0] len_q, idx, idx_nx;
  logic [7:0] cnt, cnt_nx;
  logic       rd_q, at_last;

  assign at_last = (idx == len_q - 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TX_IDLE;
      pkt_q <= '0;
      len_q <= '0;
      rd_q  <= 1'b0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      if (state == TX_IDLE && go) begin
        pkt_q <= pkt;
        len_q <= len;
        rd_q  <= rd;
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    case (state)
      TX_IDLE: if (go) begin
        state_nx = TX_SEND;
        idx_nx   = '0;
      end
      TX_SEND: begin
        state_nx = TX_GAP;
        cnt_nx   = GAP_LOAD;
      end
      // The cycle after cnt reaches 1 is exactly STROBE_GAP after the strobe.
      TX_GAP: begin
        if (cnt > 8'd1) cnt_nx = cnt - 8'd1;
        else if (!at_last) begin
          state_nx = TX_SEND;
          idx_nx   = idx + 3'd1;
        end else state_nx = rd_q ? TX_SAMPLE : TX_IDLE;
      end
      TX_SAMPLE: state_nx = TX_IDLE;
      default:   state_nx = TX_IDLE;
    endcase
  end

  assign strobe = (state == TX_SEND);
  assign start  = strobe && (idx == 3'd0);
  assign dout   = strobe ? pkt_q[idx] : 8'h00;
  assign last   = strobe && at_last;
  assign sample = (state == TX_SAMPLE);
  assign idle   = (state == TX_IDLE);
  assign cmd    = pkt_q[0];
endmodule

// File: rtl/hid_host.sv
// HID byte-protocol initiator: init sequence, one-entry source holding regs,
// fixed-priority arbitration, irq service and reply capture.
module hid_host import hid_pkg::*; #(
  parameter int STROBE_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hid_strobe,
  output logic       hid_start,
  output logic [7:0] hid_dout,
  input  logic [7:0] hid_din,
  input  logic       hid_irq,
  output logic       hid_iack,
  input  logic       kbd_valid,
  output logic       kbd_ready,
  input  logic [7:0] kbd_code,
  input  logic       mouse_valid,
  output logic       mouse_ready,
  input  logic [1:0] mouse_btns,
  input  logic [7:0] mouse_x,
  input  logic [7:0] mouse_y,
  input  logic       joy_valid,
  output logic       joy_ready,
  input  logic       joy_dev,
  input  logic [7:0] joy_dig,
  input  logic [7:0] joy_ax,
  input  logic [7:0] joy_ay,
  input  logic [7:0] joy_btn,
  output logic [5:0] db9_state,
  output logic       db9_valid,
  output logic       status_ok,
  output logic       busy
);
  host_state_t state, state_nx;
  logic       kbd_full, mouse_full, joy_full, alive;
  logic [7:0] kbd_q, mx_q, my_q, jdig_q, jax_q, jay_q, jbtn_q;
  logic [1:0] btns_q;
  logic       jdev_q, irq_prev, irq_pend, irq_rise;
  logic       go, rd, tx_last, tx_sample, tx_idle;
  logic [2:0] len;
  logic [7:0] tx_cmd;
  pkt_t       pkt;

  assign irq_rise = hid_irq & ~irq_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= H_INIT_STAT;
      alive <= 1'b0;
      irq_prev <= 1'b0;
      irq_pend <= 1'b0;
      kbd_full <= 1'b0; mouse_full <= 1'b0; joy_full <= 1'b0;
      kbd_q <= '0; btns_q <= '0; mx_q <= '0; my_q <= '0;
      jdev_q <= 1'b0; jdig_q <= '0; jax_q <= '0; jay_q <= '0; jbtn_q <= '0;
      db9_state <= '0;
      db9_valid <= 1'b0;
      status_ok <= 1'b0;
    end else begin
      state <= state_nx;
      alive <= 1'b1;
      irq_prev <= hid_irq;
      // A new edge in the iack cycle re-arms the request rather than being lost.
      irq_pend <= irq_rise | (irq_pend & ~hid_iack);
      if (kbd_valid && kbd_ready) begin
        kbd_full <= 1'b1;
        kbd_q    <= kbd_code;
      end else if (tx_last && tx_cmd == CMD_KBD) kbd_full <= 1'b0;
      if (mouse_valid && mouse_ready) begin
        mouse_full <= 1'b1;
        btns_q <= mouse_btns; mx_q <= mouse_x; my_q <= mouse_y;
      end else if (tx_last && tx_cmd == CMD_MOUSE) mouse_full <= 1'b0;
      if (joy_valid && joy_ready) begin
        joy_full <= 1'b1;
        jdev_q <= joy_dev; jdig_q <= joy_dig; jax_q <= joy_ax; jay_q <= joy_ay; jbtn_q <= joy_btn;
      end else if (tx_last && tx_cmd == CMD_JOY) joy_full <= 1'b0;
      db9_valid <= 1'b0;
      if (tx_sample) begin
        if (state == H_INIT_STAT) status_ok <= (hid_din == 8'h01);
        else begin
          db9_state <= hid_din[5:0];
          db9_valid <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    hid_iack = 1'b0;
    pkt      = '0;
    case (state)
      H_INIT_STAT: begin
        pkt[0] = CMD_STATUS;
        go     = tx_idle;
        if (tx_sample) state_nx = H_INIT_ARM;
      end
      H_INIT_ARM: begin
        pkt[0] = CMD_DB9;
        go     = tx_idle;
        if (tx_sample) state_nx = H_IDLE;
      end
      H_IDLE: if (tx_idle) begin
        if (irq_pend) begin
          pkt[0] = CMD_DB9;
          go = 1'b1;
          hid_iack = 1'b1;
        end else if (kbd_full) begin
          pkt[0] = CMD_KBD; pkt[1] = kbd_q;
          go = 1'b1;
        end else if (mouse_full) begin
          pkt[0] = CMD_MOUSE; pkt[1] = {6'b0, btns_q}; pkt[2] = mx_q; pkt[3] = my_q;
          go = 1'b1;
        end else if (joy_full) begin
          pkt[0] = CMD_JOY; pkt[1] = {7'b0, jdev_q}; pkt[2] = jdig_q;
          pkt[3] = jax_q; pkt[4] = jay_q; pkt[5] = jbtn_q;
          go = 1'b1;
        end
      end
      default: state_nx = H_INIT_STAT;
    endcase
  end

  assign len = pkt_len(pkt[0]);
  assign rd  = (pkt[0] == CMD_STATUS) || (pkt[0] == CMD_DB9);

  hid_pkt_tx #(.STROBE_GAP(STROBE_GAP)) u_tx (
    .clk(clk), .rst(reset), .go(go), .pkt(pkt), .len(len), .rd(rd),
    .strobe(hid_strobe), .start(hid_start), .dout(hid_dout), .last(tx_last),
    .sample(tx_sample), .idle(tx_idle), .cmd(tx_cmd)
  );

  assign busy        = ~tx_idle;
  assign kbd_ready   = alive & ~kbd_full;
  assign mouse_ready = alive & ~mouse_full;
  assign joy_ready   = alive & ~joy_full;
endmodule
